// File: rtl/wb_initiator_if.sv
// wb_initiator_if: request/response channel and Wishbone classic bus grouped
// for the wb_initiator block. The master modport is the initiator's view;
// the slave modport is the view of whoever drives requests and models the
// Wishbone target (test harness or surrounding logic).
interface wb_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_sel, rsp_ready,
           wbm_dat_i, wbm_ack_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
           busy
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_sel, rsp_ready,
           wbm_dat_i, wbm_ack_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
           busy
  );
endinterface

// File: rtl/wb_initiator.sv
// wb_initiator: single-beat Wishbone classic (B4) initiator with a watchdog.
// A valid/ready request becomes one read or write cycle; the outcome (read
// data or timeout error) is returned on a valid/ready response channel.
// Optional build macro WB_INITIATOR_RETRY_EN: after the first timeout the
// cycle is dropped for one clock and retried once before reporting an error.
module wb_initiator #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 16
) (
  input logic            clk,
  input logic            reset,
  wb_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, CYC, RESP, RETRY} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] timer;
  logic            cyc_q;
  logic            stb_q;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [31:0]     adr_q;
  logic [31:0]     dat_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic            busy_q;
`ifdef WB_INITIATOR_RETRY_EN
  logic            retried;
`endif

  // Request acceptance is combinational so a request can be taken the same
  // cycle the block returns to IDLE; held off while reset is asserted.
  assign bus.req_ready = (state == IDLE) && !reset;

  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

  // Transaction FSM: all bus, response and busy outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef WB_INITIATOR_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            we_q   <= bus.req_we;
            sel_q  <= bus.req_sel;
            adr_q  <= bus.req_addr;
            // Reads drive zero on the write-data lines.
            dat_q  <= bus.req_we ? bus.req_wdata : 32'h0;
            timer  <= '0;
            busy_q <= 1'b1;
            state  <= CYC;
`ifdef WB_INITIATOR_RETRY_EN
            retried <= 1'b0;
`endif
          end
        end
        CYC: begin
          // Ack takes priority over a coincident timeout.
          if (bus.wbm_ack_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? 32'h0 : bus.wbm_dat_i;
            rsp_err_q   <= 1'b0;
            state       <= RESP;
          end else if (timer == TO_LAST) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
`ifdef WB_INITIATOR_RETRY_EN
            if (!retried) begin
              retried <= 1'b1;
              state   <= RETRY;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'h0;
              rsp_err_q   <= 1'b1;
              state       <= RESP;
            end
`else
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
`endif
          end else begin
            timer <= timer + TO_W'(1);
          end
        end
`ifdef WB_INITIATOR_RETRY_EN
        RETRY: begin
          // One idle bus cycle has passed; re-issue the latched transfer.
          cyc_q <= 1'b1;
          stb_q <= 1'b1;
          timer <= '0;
          state <= CYC;
        end
`endif
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          cyc_q  <= 1'b0;
          stb_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: directed and randomized transactions against wb_initiator,
// with expected timing and results computed from a transaction-level model.
module tb_wb_initiator;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  wb_initiator_if bus();

  wb_initiator #(.TIMEOUT(T), .TO_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: the slave acks in cycle N+a (a=0: never) where
  // N is the acceptance cycle. Returns the response cycle offset R, the cycle
  // offset L where cyc is dropped for a retry (-1 if none) and success flag.
  task automatic model(input int a, output int r, output int l, output logic ok);
    l = -1;
    if (a >= 1 && a <= T) begin
      ok = 1'b1; r = a + 1;
    end else begin
`ifdef WB_INITIATOR_RETRY_EN
      l = T + 1;
      if (a >= T + 2 && a <= 2 * T + 1) begin
        ok = 1'b1; r = a + 1;
      end else begin
        ok = 1'b0; r = 2 * T + 2;
      end
`else
      ok = 1'b0; r = T + 1;
`endif
    end
  endtask

  // One complete transaction, called at #1 after an edge with the DUT idle.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] sel, input int a, input logic [31:0] sdata,
                     input int hold);
    int r, l;
    logic ok, exp_cyc;
    logic [31:0] exp_rd;
    model(a, r, l, ok);
    exp_rd = (ok && !we) ? sdata : 32'h0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_sel = sel; bus.wbm_dat_i = sdata;
    bus.wbm_ack_i = 1'b0; bus.rsp_ready = (hold == 0);
    chk("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
    step();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= r; k++) begin
      bus.wbm_ack_i = (k == a);
      exp_cyc = (k < r) && (k != l);
      chk("cyc", {31'h0, bus.wbm_cyc_o}, {31'h0, exp_cyc});
      chk("stb", {31'h0, bus.wbm_stb_o}, {31'h0, exp_cyc});
      chk("rsp_valid", {31'h0, bus.rsp_valid}, {31'h0, (k == r)});
      chk("req_ready_busy", {31'h0, bus.req_ready}, 32'h0);
      chk("busy", {31'h0, bus.busy}, 32'h1);
      if (exp_cyc) begin
        chk("adr", bus.wbm_adr_o, addr);
        chk("we", {31'h0, bus.wbm_we_o}, {31'h0, we});
        chk("sel", {28'h0, bus.wbm_sel_o}, {28'h0, sel});
        chk("dat_o", bus.wbm_dat_o, we ? wdata : 32'h0);
      end
      if (k < r) step();
    end
    bus.wbm_ack_i = 1'b0;
    chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, !ok});
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    for (int h = 1; h <= hold; h++) begin
      step();
      chk("hold_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_err", {31'h0, bus.rsp_err}, {31'h0, !ok});
      chk("hold_req_ready", {31'h0, bus.req_ready}, 32'h0);
      if (h == hold) bus.rsp_ready = 1'b1;
    end
    step();
    chk("done_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("done_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("done_busy", {31'h0, bus.busy}, 32'h0);
    // A stray ack while idle must not produce anything.
    bus.wbm_ack_i = 1'b1;
    step();
    bus.wbm_ack_i = 1'b0;
    chk("stray_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("stray_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
    step();
    chk("stray_valid2", {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] a1, a2, d2;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_sel = '0; bus.rsp_ready = 1'b1; bus.wbm_dat_i = '0; bus.wbm_ack_i = 1'b0;

    // Reset state
    step(); step();
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("rst_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, bus.wbm_stb_o}, 32'h0);
    chk("rst_adr", bus.wbm_adr_o, 32'h0);
    chk("rst_dat", bus.wbm_dat_o, 32'h0);
    chk("rst_sel", {28'h0, bus.wbm_sel_o}, 32'h0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    reset = 1'b0;
    step();

    // Directed: write with ack two cycles after stb, read with immediate ack
    txn(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF, 3, 32'hDEAD_BEEF, 0);
    txn(1'b0, 32'h3000_0000, 32'h1111_2222, 4'hF, 1, 32'h0000_000F, 0);
    // Timeout with no ack, ack exactly on the last window cycle
    txn(1'b0, 32'h3000_0004, 32'h0, 4'h3, 0, 32'h1234_5678, 0);
    txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, T, 32'hCAFE_F00D, 0);
    // Backpressure on the response channel
    txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 2, 32'h5A5A_A5A5, 5);

    // Held request is taken only after the response handshake
    a1 = 32'h3000_0010; a2 = 32'h3000_0014; d2 = 32'h0BAD_CAFE;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a1; bus.req_sel = 4'hF;
    bus.wbm_dat_i = 32'h7777_0001; bus.rsp_ready = 1'b0;
    step();
    bus.req_addr = a2;
    bus.wbm_ack_i = 1'b1;
    step();
    bus.wbm_ack_i = 1'b0;
    for (int h = 0; h < 5; h++) begin
      chk("bp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("bp_rdata", bus.rsp_rdata, 32'h7777_0001);
      chk("bp_req_ready", {31'h0, bus.req_ready}, 32'h0);
      chk("bp_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_accept_ready", {31'h0, bus.req_ready}, 32'h1);
    step();
    bus.req_valid = 1'b0;
    bus.wbm_dat_i = d2;
    chk("bp_next_cyc", {31'h0, bus.wbm_cyc_o}, 32'h1);
    chk("bp_next_adr", bus.wbm_adr_o, a2);
    bus.wbm_ack_i = 1'b1;
    step();
    bus.wbm_ack_i = 1'b0;
    chk("bp_next_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("bp_next_rdata", bus.rsp_rdata, d2);
    step();
    chk("bp_next_done", {31'h0, bus.rsp_valid}, 32'h0);

    // Reset in the third CYC cycle
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h3000_0020;
    step();
    bus.req_valid = 1'b0;
    chk("rmid_cyc1", {31'h0, bus.wbm_cyc_o}, 32'h1);
    step(); step();
    chk("rmid_cyc3", {31'h0, bus.wbm_cyc_o}, 32'h1);
    reset = 1'b1;
    step();
    chk("rmid_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
    chk("rmid_stb", {31'h0, bus.wbm_stb_o}, 32'h0);
    chk("rmid_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rmid_req_ready", {31'h0, bus.req_ready}, 32'h0);
    reset = 1'b0;
    step();
    chk("rmid_ready_after", {31'h0, bus.req_ready}, 32'h1);
    chk("rmid_valid_after", {31'h0, bus.rsp_valid}, 32'h0);
    step();

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * T + 3))
                                      : int'($urandom_range(1, 4));
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), a, $urandom,
          int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
